// File: rtl/moesi_dir_ctrl_if.sv
// Request/response, invalidation and query bundle for the
// MOESI directory controller.
interface moesi_dir_ctrl_if #(
  parameter int NPROC = 4,
  parameter int NBLK  = 8
);
  localparam int PID_W = (NPROC < 2) ? 1 : $clog2(NPROC);
  localparam int BLK_W = $clog2(NBLK);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [PID_W-1:0] req_proc;
  logic [BLK_W-1:0] req_blk;

  logic             inv_valid;
  logic [PID_W-1:0] inv_proc;

  logic             resp_valid;
  logic [PID_W-1:0] resp_proc;
  logic [BLK_W-1:0] resp_blk;
  logic [2:0]       resp_state;
  logic [1:0]       resp_src;
  logic             resp_wb;
  logic             resp_err;

  logic [PID_W-1:0] q_proc;
  logic [BLK_W-1:0] q_blk;
  logic [2:0]       q_state;

  modport master (
    output req_valid, req_op, req_proc, req_blk,
    output q_proc, q_blk,
    input  req_ready, inv_valid, inv_proc,
    input  resp_valid, resp_proc, resp_blk,
    input  resp_state, resp_src, resp_wb, resp_err,
    input  q_state
  );

  modport slave (
    input  req_valid, req_op, req_proc, req_blk,
    input  q_proc, q_blk,
    output req_ready, inv_valid, inv_proc,
    output resp_valid, resp_proc, resp_blk,
    output resp_state, resp_src, resp_wb, resp_err,
    output q_state
  );
endinterface

// File: rtl/moesi_dir_ctrl.sv
// MOESI directory controller: NPROC caches x NBLK blocks,
// one request at a time, invalidations serialised one per cycle.
module moesi_dir_ctrl #(
  parameter int NPROC = 4,
  parameter int NBLK  = 8
) (
  input logic             clk,
  input logic             reset,
  moesi_dir_ctrl_if.slave bus
);
  localparam int PID_W = (NPROC < 2) ? 1 : $clog2(NPROC);
  localparam int BLK_W = $clog2(NBLK);

  typedef enum logic [2:0] {
    C_I = 3'd0,
    C_S = 3'd1,
    C_E = 3'd2,
    C_O = 3'd3,
    C_M = 3'd4
  } cst_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    INVAL,
    RESP
  } fsm_t;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_EV = 2'b10;

  localparam logic [1:0] SRC_HIT = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_C2C = 2'd2;
  localparam logic [1:0] SRC_UPG = 2'd3;

  fsm_t fsm_q, fsm_d;

  cst_t st_q [NBLK][NPROC];

  logic [1:0]       op_q;
  logic [PID_W-1:0] proc_q;
  logic [BLK_W-1:0] blk_q;

  cst_t             row_q [NPROC];
  logic [NPROC-1:0] inv_q;
  cst_t             rst_q;
  logic [1:0]       src_q;
  logic             wb_q;
  logic             err_q;

  cst_t             cur_row [NPROC];
  cst_t             cur;
  cst_t             row_d [NPROC];
  logic [NPROC-1:0] inv_d;
  cst_t             rst_d;
  logic [1:0]       src_d;
  logic             wb_d;
  logic             err_d;
  logic             any_o;
  logic             dirty_o;
  logic [PID_W-1:0] pid_i;
  logic [BLK_W-1:0] blk_i;

  logic [PID_W-1:0] victim;
  logic [NPROC-1:0] vic_oh;

  logic             accept;
  logic             q_in;
  logic [PID_W-1:0] q_pi;
  logic [BLK_W-1:0] q_bi;

  assign accept = bus.req_valid && (fsm_q == IDLE);

  assign err_d = (op_q == 2'b11)
              || (int'(proc_q) >= NPROC)
              || (int'(blk_q) >= NBLK);

  // Out-of-range requests still index safely; their result is discarded.
  assign pid_i = err_d ? '0 : proc_q;
  assign blk_i = err_d ? '0 : blk_q;

  always_comb begin
    for (int i = 0; i < NPROC; i++) begin
      cur_row[i] = st_q[blk_i][i];
    end
  end

  assign cur = cur_row[pid_i];

  always_comb begin
    any_o   = 1'b0;
    dirty_o = 1'b0;
    for (int i = 0; i < NPROC; i++) begin
      if (i != int'(pid_i) && cur_row[i] != C_I) begin
        any_o = 1'b1;
        if (cur_row[i] == C_M || cur_row[i] == C_O) begin
          dirty_o = 1'b1;
        end
      end
    end
  end

  always_comb begin
    row_d = cur_row;
    inv_d = '0;
    rst_d = C_I;
    src_d = SRC_HIT;
    wb_d  = 1'b0;
    if (!err_d) begin
      unique case (1'b1)
        (op_q == OP_RD): begin
          if (cur != C_I) begin
            rst_d = cur;
          end else if (!any_o) begin
            rst_d = C_E;
            src_d = SRC_MEM;
          end else begin
            for (int i = 0; i < NPROC; i++) begin
              if (i != int'(pid_i)) begin
                if (cur_row[i] == C_M) row_d[i] = C_O;
                if (cur_row[i] == C_E) row_d[i] = C_S;
              end
            end
            rst_d = C_S;
            src_d = dirty_o ? SRC_C2C : SRC_MEM;
          end
          row_d[pid_i] = rst_d;
        end
        (op_q == OP_WR): begin
          rst_d = C_M;
          if (cur != C_M && cur != C_E) begin
            for (int i = 0; i < NPROC; i++) begin
              if (i != int'(pid_i) && cur_row[i] != C_I) begin
                inv_d[i] = 1'b1;
                row_d[i] = C_I;
              end
            end
            if (cur == C_S || cur == C_O) src_d = SRC_UPG;
            else src_d = dirty_o ? SRC_C2C : SRC_MEM;
          end
          row_d[pid_i] = C_M;
        end
        (op_q == OP_EV): begin
          wb_d = (cur == C_M) || (cur == C_O);
          row_d[pid_i] = C_I;
        end
        default: ;
      endcase
    end
  end

  // Lowest pending index is invalidated first.
  always_comb begin
    victim = '0;
    vic_oh = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (inv_q[i]) begin
        victim = PID_W'(i);
        vic_oh = '0;
        vic_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:   if (accept) fsm_d = LOOKUP;
      LOOKUP: fsm_d = (inv_d != '0) ? INVAL : RESP;
      INVAL:  if ((inv_q & ~vic_oh) == '0) fsm_d = RESP;
      RESP:   fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= IDLE;
      op_q   <= '0;
      proc_q <= '0;
      blk_q  <= '0;
      inv_q  <= '0;
      rst_q  <= C_I;
      src_q  <= '0;
      wb_q   <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < NPROC; i++) begin
        row_q[i] <= C_I;
      end
      for (int b = 0; b < NBLK; b++) begin
        for (int p = 0; p < NPROC; p++) begin
          st_q[b][p] <= C_I;
        end
      end
    end else begin
      fsm_q <= fsm_d;
      unique case (fsm_q)
        IDLE: begin
          if (accept) begin
            op_q   <= bus.req_op;
            proc_q <= bus.req_proc;
            blk_q  <= bus.req_blk;
          end
        end
        LOOKUP: begin
          row_q <= row_d;
          inv_q <= inv_d;
          rst_q <= rst_d;
          src_q <= src_d;
          wb_q  <= wb_d;
          err_q <= err_d;
        end
        INVAL: inv_q <= inv_q & ~vic_oh;
        RESP: begin
          if (!err_q) st_q[blk_q] <= row_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (fsm_q == IDLE);
  assign bus.inv_valid  = (fsm_q == INVAL);
  assign bus.inv_proc   = (fsm_q == INVAL) ? victim : '0;
  assign bus.resp_valid = (fsm_q == RESP);

  always_comb begin
    bus.resp_proc  = '0;
    bus.resp_blk   = '0;
    bus.resp_state = '0;
    bus.resp_src   = '0;
    bus.resp_wb    = 1'b0;
    bus.resp_err   = 1'b0;
    if (fsm_q == RESP) begin
      bus.resp_proc  = proc_q;
      bus.resp_blk   = blk_q;
      bus.resp_state = rst_q;
      bus.resp_src   = src_q;
      bus.resp_wb    = wb_q;
      bus.resp_err   = err_q;
    end
  end

  assign q_in = (int'(bus.q_proc) < NPROC)
             && (int'(bus.q_blk) < NBLK);
  assign q_pi = q_in ? bus.q_proc : '0;
  assign q_bi = q_in ? bus.q_blk : '0;
  assign bus.q_state = q_in ? st_q[q_bi][q_pi] : C_I;

endmodule

// File: tb/tb_moesi_dir_ctrl.sv
// Randomised bench for moesi_dir_ctrl against a rule-level
// MOESI model (non-pow2 sizes so range errors are reachable).
module tb_moesi_dir_ctrl;
  localparam int NPROC = 5;
  localparam int NBLK  = 6;
  localparam int I = 0, S = 1, E = 2, O = 3, M = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  moesi_dir_ctrl_if #(.NPROC(NPROC), .NBLK(NBLK)) bus ();

  moesi_dir_ctrl #(.NPROC(NPROC), .NBLK(NBLK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  int mst [NBLK][NPROC];
  int e_state, e_src, e_wb, e_err;
  int e_vic [$];
  int g_state, g_src, g_wb, g_err, g_cyc;
  int g_inv [$];

  task automatic model_clear();
    for (int b = 0; b < NBLK; b++)
      for (int p = 0; p < NPROC; p++)
        mst[b][p] = I;
  endtask

  task automatic model(int op, int p, int b);
    int  cur;
    bit  anyv, dirty;
    e_vic.delete();
    e_state = I; e_src = 0; e_wb = 0;
    e_err = (op == 3 || p >= NPROC || b >= NBLK);
    if (e_err) return;
    cur = mst[b][p];
    anyv = 0; dirty = 0;
    for (int q = 0; q < NPROC; q++) begin
      if (q != p && mst[b][q] != I) anyv = 1;
      if (q != p && (mst[b][q] == M || mst[b][q] == O))
        dirty = 1;
    end
    case (op)
      0: begin
        if (cur != I) e_state = cur;
        else if (!anyv) begin
          e_state = E; e_src = 1;
        end else begin
          for (int q = 0; q < NPROC; q++) begin
            if (q != p && mst[b][q] == M) mst[b][q] = O;
            if (q != p && mst[b][q] == E) mst[b][q] = S;
          end
          e_state = S;
          e_src = dirty ? 2 : 1;
        end
        mst[b][p] = e_state;
      end
      1: begin
        if (cur != M && cur != E) begin
          for (int q = 0; q < NPROC; q++)
            if (q != p && mst[b][q] != I) begin
              e_vic.push_back(q);
              mst[b][q] = I;
            end
          if (cur == S || cur == O) e_src = 3;
          else e_src = dirty ? 2 : 1;
        end
        e_state = M;
        mst[b][p] = M;
      end
      default: begin
        e_wb = (cur == M || cur == O);
        mst[b][p] = I;
      end
    endcase
  endtask

  task automatic qchk(int p, int b, int exp);
    bus.q_proc = 3'(p);
    bus.q_blk  = 3'(b);
    #1;
    chk($sformatf("q_state p%0d b%0d", p, b),
        32'(bus.q_state), 32'(exp));
  endtask

  task automatic do_req(int op, int p, int b);
    int  c, n;
    bit  done, iv;
    model(op, p, b);
    n = e_vic.size();
    g_inv.delete();
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'(op);
    bus.req_proc  = 3'(p);
    bus.req_blk   = 3'(b);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_proc  = 3'($urandom);
    bus.req_blk   = 3'($urandom);
    c = 1;
    done = 0;
    while (!done && c < 40) begin
      iv = (c >= 2 && c - 2 < n);
      chk("inv_valid", 32'(bus.inv_valid), 32'(iv));
      if (bus.inv_valid) g_inv.push_back(int'(bus.inv_proc));
      if (iv) chk("inv_proc", 32'(bus.inv_proc), 32'(e_vic[c-2]));
      if (bus.resp_valid) begin
        done = 1;
        g_cyc   = c;
        g_state = int'(bus.resp_state);
        g_src   = int'(bus.resp_src);
        g_wb    = int'(bus.resp_wb);
        g_err   = int'(bus.resp_err);
      end else begin
        @(negedge clk);
        c++;
      end
    end
    if (!done) begin
      chk("resp timeout", 0, 1);
      return;
    end
    chk("resp_cycle", 32'(g_cyc), 32'(2 + n));
    chk("resp_state", 32'(g_state), 32'(e_state));
    chk("resp_src", 32'(g_src), 32'(e_src));
    chk("resp_wb", 32'(g_wb), 32'(e_wb));
    chk("resp_err", 32'(g_err), 32'(e_err));
    chk("resp_proc", 32'(bus.resp_proc), 32'(p));
    chk("resp_blk", 32'(bus.resp_blk), 32'(b));
    @(negedge clk);
    if (b < NBLK)
      for (int q = 0; q < NPROC; q++) qchk(q, b, mst[b][q]);
    begin
      int rb, rp;
      rb = $urandom_range(0, NBLK - 1);
      rp = $urandom_range(0, NPROC - 1);
      qchk(rp, rb, mst[rb][rp]);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_proc  = '0;
    bus.req_blk   = '0;
    bus.q_proc    = '0;
    bus.q_blk     = '0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst req_ready", 32'(bus.req_ready), 1);
    chk("rst resp_valid", 32'(bus.resp_valid), 0);
    chk("rst inv_valid", 32'(bus.inv_valid), 0);
    chk("rst resp_state", 32'(bus.resp_state), 0);
    qchk(0, 3, I);
    qchk(NPROC - 1, NBLK - 1, I);

    do_req(0, 0, 3);
    chk("d1 state", 32'(g_state), E);
    chk("d1 src", 32'(g_src), 1);
    chk("d1 cyc", 32'(g_cyc), 2);
    qchk(0, 3, E);
    do_req(0, 1, 3);
    chk("d2 state", 32'(g_state), S);
    qchk(0, 3, S);
    do_req(1, 2, 3);
    chk("d3 cyc", 32'(g_cyc), 4);
    chk("d3 state", 32'(g_state), M);
    chk("d3 src", 32'(g_src), 1);
    chk("d3 ninv", 32'(g_inv.size()), 2);
    do_req(1, 0, 1);
    do_req(0, 1, 1);
    chk("d4 src", 32'(g_src), 2);
    qchk(0, 1, O);
    do_req(2, 0, 1);
    chk("d5 wb", 32'(g_wb), 1);
    qchk(0, 1, I);
    qchk(1, 1, S);
    do_req(0, 1, 5);
    do_req(1, 1, 5);
    chk("d6 cyc", 32'(g_cyc), 2);
    chk("d6 state", 32'(g_state), M);
    chk("d6 src", 32'(g_src), 0);
    chk("d6 ninv", 32'(g_inv.size()), 0);
    do_req(3, 0, 0);
    chk("e1 err", 32'(g_err), 1);
    do_req(0, 0, NBLK);
    chk("e2 err", 32'(g_err), 1);
    chk("e2 cyc", 32'(g_cyc), 2);
    do_req(0, NPROC, 0);
    chk("e3 err", 32'(g_err), 1);
    qchk(NPROC, 0, I);

    // Three sharers on b2, then a write from p3 cut by reset.
    do_req(0, 0, 2);
    do_req(0, 1, 2);
    do_req(0, 2, 2);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_proc  = 3'd3;
    bus.req_blk   = 3'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rm inv c2", 32'(bus.inv_valid), 1);
    @(negedge clk);
    chk("rm inv c3", 32'(bus.inv_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rm req_ready", 32'(bus.req_ready), 1);
    chk("rm resp_valid", 32'(bus.resp_valid), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rm no resp", 32'(bus.resp_valid), 0);
    end
    model_clear();
    for (int b = 0; b < NBLK; b++)
      for (int p = 0; p < NPROC; p++) qchk(p, b, I);

    for (int k = 0; k < 400; k++) begin
      int op, p, b;
      op = ($urandom_range(0, 15) == 0) ? 3
         : int'($urandom_range(0, 2));
      p = ($urandom_range(0, 19) == 0)
        ? int'($urandom_range(NPROC, 7))
        : int'($urandom_range(0, NPROC - 1));
      b = ($urandom_range(0, 19) == 0)
        ? int'($urandom_range(NBLK, 7))
        : int'($urandom_range(0, 2));
      do_req(op, p, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
